// File: rtl/twiddle_sequencer_if.sv
// Twiddle-factor stream between the sequencer and the butterfly datapath.
//   master : sequencer side, drives the factor, its tags and tw_valid
//   slave  : consumer side, drives tw_ready
// A factor transfers on a rising clock edge when tw_valid and tw_ready are
// both high. While tw_valid is high and tw_ready is low, the factor and its
// tags do not change.
interface twiddle_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int LOG2N = 3
);
  logic                    tw_valid;
  logic                    tw_ready;
  logic signed [WIDTH-1:0] w_real;
  logic signed [WIDTH-1:0] w_imag;
  logic [LOG2N-1:0]        tw_stage;
  logic [LOG2N-2:0]        tw_bfly;
  logic [LOG2N-2:0]        tw_k;
  logic                    tw_last;

  modport master (
    output tw_valid, w_real, w_imag, tw_stage, tw_bfly, tw_k, tw_last,
    input  tw_ready
  );

  modport slave (
    input  tw_valid, w_real, w_imag, tw_stage, tw_bfly, tw_k, tw_last,
    output tw_ready
  );
endinterface

// File: rtl/twiddle_sequencer.sv
// Radix-2 DIT twiddle-factor sequencer. A start request makes it walk every
// stage s and butterfly b of an N = 2^LOG2N point transform. For each pair it
// emits W_N^k with k = (b & (2^s-1)) << (LOG2N-1-s). Factors come out as
// signed Q1.(WIDTH-1) values from a quarter-wave-free half-circle ROM that is
// built at elaboration.
//
// Ports:
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   start      begins a sweep; only looked at in IDLE
//   inverse    0 = forward (imag = -sin), 1 = inverse (imag = +sin);
//              captured together with start
//   busy       high while factors of the current sweep are being presented
//   done       one-cycle pulse after the last factor has been accepted
//   tw         master side of twiddle_sequencer_if (factor, tags, handshake)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start
// RUN   | presenting factors; the sweep ends when tw_last is accepted
// DONE  | single cycle with done=1, then back to IDLE
module twiddle_sequencer #(
  parameter int WIDTH = 8,
  parameter int LOG2N = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic inverse,
  output logic busy,
  output logic done,
  twiddle_sequencer_if.master tw
);

  localparam int  HALF = 1 << (LOG2N - 1);
  localparam int  SW   = LOG2N;
  localparam int  BW   = LOG2N - 1;
  localparam real PI   = 3.14159265358979323846;

  localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
  localparam logic [BW-1:0] B_LAST = BW'(HALF - 1);

  // Half-circle table, entry k packed at [k*WIDTH +: WIDTH]. Full scale is
  // 2^(WIDTH-1)-1 so the negated sine always fits in WIDTH bits.
  function automatic logic [HALF*WIDTH-1:0] build_rom(input bit sine);
    logic [HALF*WIDTH-1:0] tab;
    real                   amp;
    real                   ang;
    real                   v;
    int                    code;
    tab = '0;
    amp = real'((2 ** (WIDTH - 1)) - 1);
    for (int k = 0; k < HALF; k++) begin
      ang = 2.0 * PI * real'(k) / real'(2 * HALF);
      v   = sine ? $sin(ang) : $cos(ang);
      v   = v * amp;
      // Round half away from zero.
      code = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
      tab[k*WIDTH +: WIDTH] = code[WIDTH-1:0];
    end
    return tab;
  endfunction

  localparam logic [HALF*WIDTH-1:0] COS_ROM = build_rom(1'b0);
  localparam logic [HALF*WIDTH-1:0] SIN_ROM = build_rom(1'b1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [SW-1:0] s_cnt;
  logic [BW-1:0] b_cnt;
  logic          pend;    // counters point at a factor not yet loaded
  logic          inv_q;

  logic                    hs;
  logic                    load;
  logic                    cnt_last;
  logic [BW-1:0]           k_mask;
  logic [BW-1:0]           k_nxt;
  logic signed [WIDTH-1:0] cos_k;
  logic signed [WIDTH-1:0] sin_k;
  logic signed [WIDTH-1:0] imag_nxt;

  assign hs       = tw.tw_valid & tw.tw_ready;
  // Output register refills when empty or when its factor is being taken,
  // which keeps one factor per cycle under continuous tw_ready.
  assign load     = pend & (~tw.tw_valid | tw.tw_ready);
  assign cnt_last = (s_cnt == S_LAST) && (b_cnt == B_LAST);

  always_comb begin
    k_mask = '0;
    for (int i = 0; i < BW; i++) begin
      if (i < int'(s_cnt)) k_mask[i] = 1'b1;
    end
    // For s = 0 the mask is empty, so the full-width shift is harmless.
    k_nxt = (b_cnt & k_mask) << (BW - int'(s_cnt));
  end

  always_comb begin
    cos_k    = COS_ROM[int'(k_nxt)*WIDTH +: WIDTH];
    sin_k    = SIN_ROM[int'(k_nxt)*WIDTH +: WIDTH];
    imag_nxt = inv_q ? sin_k : -sin_k;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (hs && tw.tw_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = tw.tw_valid;
    done = (state == DONE);
  end

  // Sweep counters and the registered ROM / tag stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_cnt       <= '0;
      b_cnt       <= '0;
      pend        <= 1'b0;
      inv_q       <= 1'b0;
      tw.tw_valid <= 1'b0;
      tw.w_real   <= '0;
      tw.w_imag   <= '0;
      tw.tw_stage <= '0;
      tw.tw_bfly  <= '0;
      tw.tw_k     <= '0;
      tw.tw_last  <= 1'b0;
    end else if (state == IDLE && start) begin
      inv_q <= inverse;
      s_cnt <= '0;
      b_cnt <= '0;
      pend  <= 1'b1;
    end else if (load) begin
      tw.tw_valid <= 1'b1;
      tw.w_real   <= cos_k;
      tw.w_imag   <= imag_nxt;
      tw.tw_stage <= s_cnt;
      tw.tw_bfly  <= b_cnt;
      tw.tw_k     <= k_nxt;
      tw.tw_last  <= cnt_last;
      if (cnt_last) begin
        pend <= 1'b0;
      end else if (b_cnt == B_LAST) begin
        b_cnt <= '0;
        s_cnt <= s_cnt + 1'b1;
      end else begin
        b_cnt <= b_cnt + 1'b1;
      end
    end else if (hs) begin
      tw.tw_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_twiddle_sequencer.sv
module tb_twiddle_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start, inverse, busy, done;
  logic start2, inverse2, busy2, done2;

  twiddle_sequencer_if #(.WIDTH(8),  .LOG2N(3)) tw8 ();
  twiddle_sequencer_if #(.WIDTH(12), .LOG2N(4)) tw16 ();

  twiddle_sequencer #(.WIDTH(8), .LOG2N(3)) dut8 (
    .clk(clk), .rst(rst), .start(start), .inverse(inverse),
    .busy(busy), .done(done), .tw(tw8)
  );

  twiddle_sequencer #(.WIDTH(12), .LOG2N(4)) dut16 (
    .clk(clk), .rst(rst), .start(start2), .inverse(inverse2),
    .busy(busy2), .done(done2), .tw(tw16)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Hand-computed 8-point tables (scale 127) and exponent order.
  int C8[4]  = '{127, 90, 0, -90};
  int S8[4]  = '{0, 90, 127, 90};
  int K8[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
  // Hand-computed 16-point tables (scale 2047).
  int C16[8] = '{2047, 1891, 1447, 783, 0, -783, -1447, -1891};
  int S16[8] = '{0, 783, 1447, 1891, 2047, 1891, 1447, 783};

  int o_re[64], o_im[64], o_s[64], o_b[64], o_k[64], o_l[64];

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] snap8();
    return {7'd0, tw8.tw_valid, tw8.tw_last, tw8.w_real, tw8.w_imag,
            tw8.tw_stage, tw8.tw_bfly, tw8.tw_k};
  endfunction

  // mode 0: ready always high; 1: stall pattern incl. on tw_last;
  // 2: ready high, start pulse and inverse flip in mid-sweep.
  task automatic sweep8(input bit inv, input int mode, input string name);
    logic [15:0] pat;
    logic [31:0] saved;
    bit          stalled, last_stalled, got_last, rdy;
    int          cnt, cyc_last, s, b, k;
    pat = 16'b1011_0110_1101_0011;
    stalled = 0; last_stalled = 0; got_last = 0; cnt = 0; cyc_last = -1;
    saved = '0;
    @(negedge clk);
    start = 1'b1; inverse = inv; tw8.tw_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({name, " valid one cycle after start"}, tw8.tw_valid, 0);
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        chk({name, " first valid"}, tw8.tw_valid, 1);
        chk({name, " first busy"}, busy, 1);
      end
      if (stalled) chk({name, " hold"}, snap8(), saved);
      rdy = 1'b1;
      if (mode == 1) begin
        rdy = pat[cyc % 16];
        if (tw8.tw_last && !last_stalled) begin
          rdy = 1'b0;
          last_stalled = 1'b1;
        end
      end
      if (mode == 2) begin
        start   = (cnt == 5);
        inverse = (cnt >= 5) ? ~inv : inv;
      end
      tw8.tw_ready = rdy;
      if (tw8.tw_valid && rdy) begin
        if (cnt < 64) begin
          o_re[cnt] = tw8.w_real;  o_im[cnt] = tw8.w_imag;
          o_s[cnt]  = tw8.tw_stage; o_b[cnt] = tw8.tw_bfly;
          o_k[cnt]  = tw8.tw_k;     o_l[cnt] = tw8.tw_last;
        end
        cnt++;
        if (tw8.tw_last) begin
          got_last = 1'b1;
          cyc_last = cyc;
          break;
        end
      end
      stalled = tw8.tw_valid && !rdy;
      saved   = snap8();
    end
    start = 1'b0;
    chk({name, " sweep ended"}, got_last, 1);
    if (mode == 0) chk({name, " no bubbles"}, cyc_last, 11);
    if (mode == 1) chk({name, " stalled on last"}, last_stalled, 1);
    @(negedge clk);
    chk({name, " done pulse"}, done, 1);
    chk({name, " busy after last"}, busy, 0);
    chk({name, " valid after last"}, tw8.tw_valid, 0);
    start = 1'b1;  // arrives while in DONE, must be ignored
    @(negedge clk);
    start = 1'b0;
    chk({name, " done width"}, done, 0);
    @(negedge clk);
    chk({name, " start in DONE ignored"}, tw8.tw_valid, 0);
    chk({name, " count"}, cnt, 12);
    for (int i = 0; i < 12 && i < cnt; i++) begin
      s = i / 4; b = i % 4; k = K8[i];
      chk($sformatf("%s[%0d] stage", name, i), o_s[i], s);
      chk($sformatf("%s[%0d] bfly", name, i), o_b[i], b);
      chk($sformatf("%s[%0d] k", name, i), o_k[i], k);
      chk($sformatf("%s[%0d] real", name, i), o_re[i], C8[k]);
      chk($sformatf("%s[%0d] imag", name, i), o_im[i], inv ? S8[k] : -S8[k]);
      chk($sformatf("%s[%0d] last", name, i), o_l[i], (i == 11) ? 1 : 0);
    end
  endtask

  initial begin
    bit hit, got_last;
    int cnt, s, b, k;
    rst = 1'b1; start = 1'b0; inverse = 1'b0; start2 = 1'b0; inverse2 = 1'b0;
    tw8.tw_ready = 1'b1; tw16.tw_ready = 1'b1;
    #12;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset outputs", snap8(), 0);
    @(negedge clk);
    rst = 1'b0;

    sweep8(1'b0, 0, "fwd");
    sweep8(1'b1, 0, "inv");
    sweep8(1'b0, 1, "bp");
    sweep8(1'b0, 2, "dist_fwd");
    sweep8(1'b1, 2, "dist_inv");

    // Reset in the middle of stage 1.
    @(negedge clk);
    start = 1'b1; inverse = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk);
      if (tw8.tw_valid && tw8.tw_stage == 3'd1) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reached stage 1", hit, 1);
    #2 rst = 1'b1;
    #1;
    chk("async reset outputs", snap8(), 0);
    chk("async reset busy", busy, 0);
    @(negedge clk);
    chk("no done after reset", done, 0);
    rst = 1'b0;
    sweep8(1'b0, 0, "after_rst");

    // 16-point, 12-bit sweep.
    @(negedge clk);
    start2 = 1'b1; inverse2 = 1'b0;
    @(negedge clk);
    start2 = 1'b0;
    cnt = 0; got_last = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (tw16.tw_valid) begin
        if (cnt < 64) begin
          o_re[cnt] = tw16.w_real;  o_im[cnt] = tw16.w_imag;
          o_s[cnt]  = tw16.tw_stage; o_b[cnt] = tw16.tw_bfly;
          o_k[cnt]  = tw16.tw_k;     o_l[cnt] = tw16.tw_last;
        end
        cnt++;
        if (tw16.tw_last) begin
          got_last = 1'b1;
          break;
        end
      end
    end
    chk("n16 sweep ended", got_last, 1);
    chk("n16 count", cnt, 32);
    @(negedge clk);
    chk("n16 done", done2, 1);
    for (int i = 0; i < 32 && i < cnt; i++) begin
      s = i / 8; b = i % 8;
      k = (b & ((1 << s) - 1)) << (3 - s);
      chk($sformatf("n16[%0d] stage", i), o_s[i], s);
      chk($sformatf("n16[%0d] bfly", i), o_b[i], b);
      chk($sformatf("n16[%0d] k", i), o_k[i], k);
      chk($sformatf("n16[%0d] real", i), o_re[i], C16[k]);
      chk($sformatf("n16[%0d] imag", i), o_im[i], -S16[k]);
      chk($sformatf("n16[%0d] last", i), o_l[i], (i == 31) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/twiddle_sequencer.md
# twiddle_sequencer

Parametrised twiddle-factor generator for the radix-2 DIT FFT datapath. On a start request it walks every stage and butterfly of an N = 2^LOG2N point transform and emits the matching signed fixed-point twiddle factor W_N^k, one per accepted handshake. Each factor is tagged with stage, butterfly index, exponent and a last flag. It supersedes the fixed 8-point combinational lookup: width, size and forward/inverse mode are selectable, and output is flow-controlled so the butterfly pipeline can stall.

## Interface
- WIDTH, 8: twiddle component width, signed Q1.(WIDTH-1).
- LOG2N, 3: log2 of FFT size; legal range 2..10.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a full twiddle sweep; sampled only in IDLE.
- inverse  in  1  0 = forward (W = e^-j2πk/N), 1 = inverse (conjugate); sampled with start.
- busy  out  1  high from accepted start until the last factor is accepted.
- done  out  1  one-cycle pulse after the last factor is accepted.
- tw_valid  out  1  w_real/w_imag and tags are valid.
- tw_ready  in  1  consumer accepts the current factor when tw_valid & tw_ready.
- w_real  out  WIDTH  cos component, signed.
- w_imag  out  WIDTH  imaginary component, signed.
- tw_stage  out  LOG2N  stage index s.
- tw_bfly  out  LOG2N-1  butterfly index b within the stage.
- tw_k  out  LOG2N-1  twiddle exponent k.
- tw_last  out  1  high on the final factor of the sweep.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 latches inverse, clears s and b, and goes to RUN.
  - RUN: presents factors in order. When tw_last is accepted, go to DONE.
  - DONE: lasts one cycle with done=1, then returns to IDLE.
- Order: s = 0..LOG2N-1 (outer), b = 0..N/2-1 (inner). Total LOG2N·N/2 factors.
- Exponent: k = (b & (2^s − 1)) << (LOG2N−1−s).
- ROM: N/2 entries, filled at elaboration.
  - C[k] = round(cos(2πk/N)·(2^(WIDTH−1)−1)).
  - S[k] = round(sin(2πk/N)·(2^(WIDTH−1)−1)).
  - +1.0 maps to 2^(WIDTH−1)−1 (127 at WIDTH=8). The most negative code never appears.
- Output values:
  - Forward: w_real = C[k], w_imag = −S[k].
  - Inverse: w_real = C[k], w_imag = +S[k].
  - Negation is exact because −(2^(WIDTH−1)−1) is representable.
- Hold rule: while tw_valid & !tw_ready, all outputs and tags stay stable.
- Counter advance happens only on handshake. b wraps from N/2−1 to 0 and increments s.
- start while busy or in DONE is ignored. inverse changes mid-sweep have no effect.
- tw_last = (s == LOG2N−1) & (b == N/2−1).

## Timing
- Reset values: busy=0, done=0, tw_valid=0, w_real=0, w_imag=0, tw_stage=0, tw_bfly=0, tw_k=0, tw_last=0; state IDLE.
- Asserting rst mid-sweep aborts immediately. No done pulse follows.
- Start latency: start sampled high at edge T gives busy=1 and tw_valid=1 with the first factor after edge T+1. One registered ROM stage.
- Throughput: with tw_ready held high, one factor per cycle with no bubbles. The next factor appears the cycle after each handshake.
- End of sweep: last handshake at edge T drops tw_valid and busy after T and raises done for one cycle (T..T+1). Earliest new start is sampled at T+2.
- tw_valid never deasserts while busy, except for reset.

## Test plan
- Reset mid-sweep: assert rst during stage 1 with tw_valid high -> all outputs 0 asynchronously; release, then start -> sweep restarts at s=0, b=0.
- Forward, WIDTH=8, LOG2N=3, tw_ready=1: start -> 12 factors. Sequence and tags:
  - Stage 0: k = 0,0,0,0.
  - Stage 1: k = 0,2,0,2.
  - Stage 2: k = 0,1,2,3.
  - Values: k0 = (127,0), k1 = (90,−90), k2 = (0,−127), k3 = (−90,−90).
  - tw_last only on the 12th factor; done pulses one cycle later.
- Inverse, same config: imag signs flip, e.g. k1 = (90,+90) and k2 = (0,+127); real parts unchanged.
- Backpressure: drop tw_ready randomly, including on the tw_last cycle -> outputs stable while stalled; no factor lost or duplicated; count = 12.
- Start while busy, and inverse toggled mid-sweep -> ignored; sweep order and signs unchanged.
- LOG2N=4, WIDTH=12: stage 3 k = 0..7. Check against the rounded formula with scale 2047, e.g. k2 = (1447,−1447) and k4 = (0,−2047).
